// File: rtl/latch_crossing_sampler.sv
// Destination-side sampler for a latch-based crossing register: qualifies a new
// latched value after STABLE equal samples, then hands it over via valid/ack.
module latch_crossing_sampler #(
    parameter int unsigned       width  = 1,
    parameter logic [width-1:0]  init   = '0,
    parameter int unsigned       STABLE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] L_IN,
    input  logic             EN_ACK,
    output logic             UPD_VALID,
    output logic [width-1:0] UPD_DATA,
    output logic [width-1:0] D_OUT,
    output logic             GLITCH
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] s0_q;
    logic [width-1:0] cand_q, cand_d;
    logic [width-1:0] dout_q, dout_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       cnt_inc;
    logic             valid_q, valid_d;
    logic             glitch_q, glitch_d;

    // A fresh candidate goes straight to PEND when one sample is enough.
    state_t           fresh_state;
    assign fresh_state = (STABLE_C == 4'd1) ? PEND : QUAL;
    assign cnt_inc     = (cnt_q >= STABLE_C) ? cnt_q : cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        glitch_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s0_q != dout_q) begin
                    cand_d  = s0_q;
                    cnt_d   = 4'd1;
                    state_d = fresh_state;
                end
            end
            QUAL: begin
                if (s0_q == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == STABLE_C) state_d = PEND;
                end else begin
                    glitch_d = 1'b1;
                    if (s0_q == dout_q) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cand_d  = s0_q;
                        cnt_d   = 4'd1;
                        state_d = fresh_state;
                    end
                end
            end
            PEND: begin
                // The sampled input is deliberately ignored until the ack.
                if (EN_ACK) begin
                    dout_d  = cand_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == PEND);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s0_q     <= init;
            cand_q   <= init;
            dout_q   <= init;
            cnt_q    <= 4'd0;
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            s0_q     <= L_IN;
            cand_q   <= cand_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            glitch_q <= glitch_d;
        end
    end

    assign UPD_VALID = valid_q;
    assign UPD_DATA  = cand_q;
    assign D_OUT     = dout_q;
    assign GLITCH    = glitch_q;

endmodule

// File: doc/latch_crossing_sampler.md
# latch_crossing_sampler

Destination-domain consumer for a latch-based clock-domain crossing register. It samples the latched crossing value every clock and accepts a new value only after it has held steady for a programmable number of consecutive samples. It then presents the accepted value to local logic through a valid/acknowledge handshake, and keeps a committed copy that it reports. It sits directly after the crossing latch, clocked by that latch's destination clock.

## Interface
- `width`, 1: data width in bits; 1 to 64.
- `init`, {width{1'b0}}: reset value of all data registers.
- `STABLE`, 2: number of consecutive equal samples needed to qualify a new value; legal range 1 to 15.

Ports:
- `CLK`  in  1  destination clock; the same clock that gates the crossing latch.
- `RST`  in  1  reset; one clock, synchronous and active-high.
- `L_IN`  in  width  latched crossing value; may change at any time relative to `CLK`.
- `EN_ACK`  in  1  local logic accepts the pending update; only acted on while `UPD_VALID`=1.
- `UPD_VALID`  out  1  a qualified new value is pending.
- `UPD_DATA`  out  width  the pending qualified value; stable while `UPD_VALID`=1.
- `D_OUT`  out  width  last committed (acknowledged) value.
- `GLITCH`  out  1  one-cycle pulse: the candidate changed before it qualified.

## Operation
- Input stage: `s0` <= `L_IN` every edge. All decisions use `s0` only, never `L_IN` directly.
- Internal registers:
  - `cand`: candidate value, width bits.
  - `cnt`: 4-bit count that saturates at `STABLE`.
  - State machine with states IDLE, QUAL and PEND.
- IDLE:
  - If `s0` != `D_OUT`: `cand` <= `s0`, `cnt` <= 1.
  - Next state is PEND if `STABLE`==1, otherwise QUAL.
  - If `s0` == `D_OUT`: stay in IDLE.
- QUAL:
  - `s0` == `cand`: `cnt` <= `cnt`+1. When `cnt`+1 == `STABLE`, go to PEND.
  - `s0` != `cand` and `s0` == `D_OUT`: pulse `GLITCH`, go to IDLE, `cnt` <= 0.
  - `s0` != `cand` and `s0` != `D_OUT`: pulse `GLITCH`, `cand` <= `s0`, `cnt` <= 1. Go to PEND if `STABLE`==1, otherwise stay in QUAL.
- PEND:
  - `UPD_VALID`=1 and `UPD_DATA`=`cand`, both registered.
  - `s0` is ignored in this state.
  - `EN_ACK`=1: `D_OUT` <= `cand`, `UPD_VALID` <= 0, go to IDLE.
- `EN_ACK` outside PEND is ignored and has no side effects.
- After a commit, IDLE re-evaluates `s0` against the new `D_OUT` on the next edge. There is at least one cycle with `UPD_VALID`=0 between successive updates.
- `UPD_DATA` equals `cand` at all times. It is only meaningful while `UPD_VALID`=1.

## Timing
- Reset (`RST`=1 at an edge):
  - `s0`, `cand`, `D_OUT` and `UPD_DATA` take `init`.
  - `cnt`=0, state is IDLE, `UPD_VALID`=0, `GLITCH`=0.
  - Reset takes priority over `EN_ACK` and over any state in progress. A pending update is discarded and `D_OUT` is not updated.
- Latency: let edge k be the first edge at which `s0` captures a new steady value V != `D_OUT`.
  - `cnt`=1 after edge k+1.
  - `UPD_VALID` goes high after edge k+`STABLE`.
- Handshake: `EN_ACK` sampled high at an edge while `UPD_VALID`=1 means that after the same edge `D_OUT`=V and `UPD_VALID`=0.
- `UPD_VALID` stays high indefinitely until acknowledged or reset.
- `GLITCH` is high for exactly the one cycle after the edge at which QUAL saw `s0` != `cand`. Back-to-back glitches produce consecutive pulses.
- An input that reverts to `D_OUT` during QUAL never asserts `UPD_VALID`.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with `L_IN`=8'hA5, `width`=8, `init`=0 -> `D_OUT`=0, `UPD_VALID`=0, `GLITCH`=0. The update then qualifies after reset is released.
- Steady qualification:
  - `STABLE`=3, `L_IN` steps 0 -> 8'h3C and holds -> `UPD_VALID` rises after edge k+3 with `UPD_DATA`=8'h3C.
  - `EN_ACK` pulse -> `D_OUT`=8'h3C on the next cycle and `UPD_VALID`=0.
- Glitch rejection: `STABLE`=3, `L_IN` goes 0 -> 8'h11 for 1 cycle -> 0 -> `GLITCH` pulses once, `UPD_VALID` never rises, `D_OUT` stays 0.
- Candidate replacement: `STABLE`=2, `L_IN` goes 0 -> 8'h11 for 1 cycle -> 8'h22 held -> one `GLITCH` pulse, then `UPD_DATA`=8'h22 valid 2 edges after the 8'h22 capture.
- Hold and ignore:
  - In PEND with `UPD_DATA`=8'h22, change `L_IN` to 8'h33 and delay `EN_ACK` 10 cycles -> `UPD_DATA` stays 8'h22 throughout.
  - After the ack, `UPD_VALID` drops for at least 1 cycle, then requalifies with 8'h33.
- `STABLE`=1 with reset mid-PEND:
  - A new value asserts `UPD_VALID` 1 edge after capture.
  - `RST` together with `EN_ACK` -> `D_OUT`=`init`, `UPD_VALID`=0.
